// File: rtl/player_collision_probe.sv
// Corner-probe sweep around player 0's sprite against the maze tile memory.
// Each sweep latches the position, issues eight reads and updates four collision flags together.
module player_collision_probe #(
    parameter int BASE_ADDR  = 4096,
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60,
    parameter int TILE_SHIFT = 3,
    parameter int SIZE       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] player_x,
    input  logic [31:0] player_y,
    output logic [16:0] mem_addr,
    output logic        mem_rden,
    input  logic [31:0] mem_q,
    output logic        collision_up,
    output logic        collision_right,
    output logic        collision_down,
    output logic        collision_left,
    output logic        sweep_done
);
    // state | meaning
    // IDLE  | flags held, waiting for enable
    // LATCH | capture position, drive probe 0
    // ISSUE | one probe per cycle (k_q = 0..7), collect result of probe k-1
    // DRAIN | collect probe 7, load all four flags
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic signed [31:0] X_LIMIT = 32'(GRID_W << TILE_SHIFT);
    localparam logic signed [31:0] Y_LIMIT = 32'(GRID_H << TILE_SHIFT);
    localparam logic signed [31:0] SZ      = 32'(SIZE);
    localparam logic signed [31:0] SZ_M1   = 32'(SIZE - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] px_q, px_d, py_q, py_d;
    logic [16:0] addr_q, addr_d;
    logic        rden_q, rden_d;
    logic        oor_a_q, oor_a_d, oor_b_q, oor_b_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [3:0]  flags_q, flags_d;
    logic        done_q, done_d;

    logic [2:0]         probe_k;
    logic signed [31:0] base_x, base_y, probe_x, probe_y;
    logic               probe_oor;
    logic [16:0]        row_idx, col_idx, probe_addr;
    logic               hit;
    logic [7:0]         full;

    // Address generation runs one cycle ahead of the registered read port.
    always_comb begin
        probe_k = (state_q == ST_LATCH) ? 3'd0 : k_q + 3'd1;
        base_x  = (state_q == ST_LATCH) ? player_x : px_q;
        base_y  = (state_q == ST_LATCH) ? player_y : py_q;
        probe_x = base_x;
        probe_y = base_y;
        case (probe_k)
            3'd0: probe_y = base_y - 32'sd1;
            3'd1: begin probe_x = base_x + SZ_M1; probe_y = base_y - 32'sd1; end
            3'd2: probe_x = base_x + SZ;
            3'd3: begin probe_x = base_x + SZ;    probe_y = base_y + SZ_M1; end
            3'd4: probe_y = base_y + SZ;
            3'd5: begin probe_x = base_x + SZ_M1; probe_y = base_y + SZ; end
            3'd6: probe_x = base_x - 32'sd1;
            default: begin probe_x = base_x - 32'sd1; probe_y = base_y + SZ_M1; end
        endcase
        probe_oor = (probe_x < 32'sd0) || (probe_x >= X_LIMIT) ||
                    (probe_y < 32'sd0) || (probe_y >= Y_LIMIT);
        row_idx    = 17'(probe_y >>> TILE_SHIFT);
        col_idx    = 17'(probe_x >>> TILE_SHIFT);
        probe_addr = probe_oor ? 17'(BASE_ADDR)
                               : 17'(BASE_ADDR) + row_idx * 17'(GRID_W) + col_idx;
    end

    assign hit = oor_b_q | (mem_q != 32'd0);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        px_d      = px_q;
        py_d      = py_q;
        addr_d    = addr_q;
        rden_d    = 1'b0;
        oor_a_d   = oor_a_q;
        oor_b_d   = oor_a_q;
        scratch_d = scratch_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        full      = scratch_q;
        full[7]   = hit;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                px_d      = player_x;
                py_d      = player_y;
                scratch_d = 8'd0;
                k_d       = 3'd0;
                addr_d    = probe_addr;
                oor_a_d   = probe_oor;
                rden_d    = 1'b1;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (k_q != 3'd0) scratch_d[k_q - 3'd1] = hit;
                if (k_q == 3'd7) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d     = k_q + 3'd1;
                    addr_d  = probe_addr;
                    oor_a_d = probe_oor;
                    rden_d  = 1'b1;
                end
            end
            default: begin
                scratch_d = full;
                flags_d   = {|full[1:0], |full[3:2], |full[5:4], |full[7:6]};
                done_d    = 1'b1;
                state_d   = enable ? ST_LATCH : ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= 3'd0;
            px_q      <= 32'd0;
            py_q      <= 32'd0;
            addr_q    <= 17'd0;
            rden_q    <= 1'b0;
            oor_a_q   <= 1'b0;
            oor_b_q   <= 1'b0;
            scratch_q <= 8'd0;
            flags_q   <= 4'b1111;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            px_q      <= px_d;
            py_q      <= py_d;
            addr_q    <= addr_d;
            rden_q    <= rden_d;
            oor_a_q   <= oor_a_d;
            oor_b_q   <= oor_b_d;
            scratch_q <= scratch_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign mem_addr        = addr_q;
    assign mem_rden        = rden_q;
    assign collision_up    = flags_q[3];
    assign collision_right = flags_q[2];
    assign collision_down  = flags_q[1];
    assign collision_left  = flags_q[0];
    assign sweep_done      = done_q;

endmodule

// File: tb/tb_player_collision_probe.sv
// Bench for player_collision_probe: a one-wall maze memory model plus a scoreboard
// of expected read addresses and flag sets, checked as the DUT reads and pulses sweep_done.
module tb_player_collision_probe;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] player_x = 32'd0;
    logic [31:0] player_y = 32'd0;
    logic [16:0] mem_addr;
    logic        mem_rden;
    logic [31:0] mem_q = 32'd0;
    logic        collision_up, collision_right, collision_down, collision_left;
    logic        sweep_done;

    int total = 0;
    int bad = 0;
    int wall_addr = -1;
    int exp_addr_q[$];
    logic [3:0] exp_flag_q[$];
    int mon_addr;
    logic [3:0] mon_flags;

    localparam logic [31:0] WALL_WORD = 32'h8000_0000;

    player_collision_probe dut (
        .clock(clock), .reset(reset), .enable(enable),
        .player_x(player_x), .player_y(player_y),
        .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_q(mem_q),
        .collision_up(collision_up), .collision_right(collision_right),
        .collision_down(collision_down), .collision_left(collision_left),
        .sweep_done(sweep_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) mem_q <= (int'(mem_addr) == wall_addr) ? WALL_WORD : 32'h0;

    always @(negedge clock) begin
        if (!reset) begin
            if (mem_rden) begin
                total++;
                if (exp_addr_q.size() == 0) begin
                    bad++;
                    $display("FAIL addr_unexpected: got read of %0d, want no read", mem_addr);
                end else begin
                    mon_addr = exp_addr_q.pop_front();
                    if (mem_addr !== 17'(mon_addr)) begin
                        bad++;
                        $display("FAIL probe_addr: got %0d want %0d", mem_addr, mon_addr);
                    end
                end
            end
            if (sweep_done) begin
                total++;
                if (exp_flag_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected: got sweep_done=1, want 0");
                end else begin
                    mon_flags = exp_flag_q.pop_front();
                    if ({collision_up, collision_right, collision_down, collision_left} !== mon_flags) begin
                        bad++;
                        $display("FAIL flags: got %b want %b (urdl)",
                                 {collision_up, collision_right, collision_down, collision_left}, mon_flags);
                    end
                end
            end
        end
    end

    task automatic push_sweep(input int x, input int y, input int nprobe, input bit with_flags);
        int dx[8];
        int dy[8];
        bit hit[8];
        int px, py, a;
        bit oor;
        dx = '{0, 15, 16, 16, 0, 15, -1, -1};
        dy = '{-1, -1, 0, 15, 16, 16, 0, 15};
        for (int k = 0; k < 8; k++) begin
            px = x + dx[k];
            py = y + dy[k];
            oor = (px < 0) || (px >= 640) || (py < 0) || (py >= 480);
            a = oor ? 4096 : 4096 + (py / 8) * 80 + (px / 8);
            hit[k] = oor || (a == wall_addr);
            if (k < nprobe) exp_addr_q.push_back(a);
        end
        if (with_flags)
            exp_flag_q.push_back({hit[0] | hit[1], hit[2] | hit[3], hit[4] | hit[5], hit[6] | hit[7]});
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clock);
            cycles++;
            if (sweep_done) break;
            if (cycles >= budget) begin
                cycles = -1;
                break;
            end
        end
    endtask

    task automatic one_sweep(input int x, input int y, output int cyc);
        int c;
        @(negedge clock);
        player_x = x;
        player_y = y;
        enable = 1'b1;
        push_sweep(x, y, 8, 1'b1);
        @(negedge clock);
        enable = 1'b0;
        wait_done(30, c);
        cyc = (c < 0) ? -1 : c + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({collision_up, collision_right, collision_down, collision_left} !== 4'b1111) begin
            bad++; $display("FAIL reset_flags: got %b want 1111",
                            {collision_up, collision_right, collision_down, collision_left});
        end
        total++;
        if (sweep_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", sweep_done); end
        total++;
        if (mem_rden !== 1'b0) begin bad++; $display("FAIL reset_rden: got %b want 0", mem_rden); end
        total++;
        if (mem_addr !== 17'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        reset = 1'b0;
        repeat (4) @(negedge clock);
        total++;
        if (mem_rden !== 1'b0 || collision_up !== 1'b1) begin
            bad++; $display("FAIL idle_after_reset: got rden=%b up=%b want rden=0 up=1", mem_rden, collision_up);
        end
    endtask

    task automatic test_open_maze();
        int n, dones, rd;
        int d[3];
        wall_addr = -1;
        @(negedge clock);
        player_x = 100;
        player_y = 100;
        enable = 1'b1;
        for (int s = 0; s < 3; s++) push_sweep(100, 100, 8, 1'b1);
        n = 0; dones = 0; rd = 0;
        d = '{-1, -1, -1};
        while (dones < 3 && n < 60) begin
            @(negedge clock);
            n++;
            if (dones >= 1 && mem_rden) rd++;
            if (sweep_done) begin
                d[dones] = n;
                dones++;
                if (dones == 2) enable = 1'b0;
            end
        end
        total++;
        if (d[0] !== 11) begin bad++; $display("FAIL open_first_done: got cycle %0d want 11", d[0]); end
        total++;
        if (d[1] - d[0] !== 10 || d[2] - d[1] !== 10) begin
            bad++; $display("FAIL open_period: got %0d,%0d want 10,10", d[1] - d[0], d[2] - d[1]);
        end
        total++;
        if (rd !== 16) begin bad++; $display("FAIL open_rden_count: got %0d want 16", rd); end
        rd = 0;
        repeat (12) begin
            @(negedge clock);
            if (mem_rden || sweep_done) rd++;
        end
        total++;
        if (rd !== 0 || {collision_up, collision_right, collision_down, collision_left} !== 4'b0000) begin
            bad++; $display("FAIL open_idle_hold: got activity=%0d flags=%b want 0 and 0000", rd,
                            {collision_up, collision_right, collision_down, collision_left});
        end
    endtask

    task automatic test_right_wall();
        int cyc;
        wall_addr = 4988;
        one_sweep(80, 80, cyc);
        total++;
        if (cyc !== 11 || collision_right !== 1'b1) begin
            bad++; $display("FAIL right_wall: got cyc=%0d right=%b want 11 and 1", cyc, collision_right);
        end
        one_sweep(72, 80, cyc);
        total++;
        if (cyc !== 11 || collision_right !== 1'b0) begin
            bad++; $display("FAIL right_wall_clear: got cyc=%0d right=%b want 11 and 0", cyc, collision_right);
        end
    endtask

    task automatic test_edges();
        int cyc;
        wall_addr = -1;
        one_sweep(200, 0, cyc);
        total++;
        if (cyc !== 11 || collision_up !== 1'b1) begin
            bad++; $display("FAIL edge_top: got cyc=%0d up=%b want 11 and 1", cyc, collision_up);
        end
        one_sweep(624, 464, cyc);
        total++;
        if (cyc !== 11 || collision_right !== 1'b1 || collision_down !== 1'b1) begin
            bad++; $display("FAIL edge_corner: got cyc=%0d right=%b down=%b want 11,1,1",
                            cyc, collision_right, collision_down);
        end
    endtask

    task automatic test_mid_change();
        int n, dones, d1, d2;
        bit r1;
        wall_addr = 4988;
        @(negedge clock);
        player_x = 80;
        player_y = 80;
        enable = 1'b1;
        push_sweep(80, 80, 8, 1'b1);
        push_sweep(88, 80, 8, 1'b1);
        repeat (5) @(negedge clock);
        player_x = 88;
        n = 5; dones = 0; d1 = -1; d2 = -1; r1 = 1'b0;
        while (dones < 2 && n < 60) begin
            @(negedge clock);
            n++;
            if (dones == 1 && n == d1 + 1) enable = 1'b0;
            if (sweep_done) begin
                dones++;
                if (dones == 1) begin d1 = n; r1 = collision_right; end
                else d2 = n;
            end
        end
        enable = 1'b0;
        total++;
        if (d1 !== 11 || r1 !== 1'b1) begin
            bad++; $display("FAIL midchange_first: got cyc=%0d right=%b want 11 and 1", d1, r1);
        end
        total++;
        if (d2 !== 21 || collision_right !== 1'b0) begin
            bad++; $display("FAIL midchange_second: got cyc=%0d right=%b want 21 and 0", d2, collision_right);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        wall_addr = 4988;
        @(negedge clock);
        player_x = 80;
        player_y = 80;
        enable = 1'b1;
        push_sweep(80, 80, 4, 1'b0);
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        total++;
        if ({collision_up, collision_right, collision_down, collision_left} !== 4'b1111 ||
            sweep_done !== 1'b0 || mem_rden !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got flags=%b done=%b rden=%b want 1111,0,0",
                            {collision_up, collision_right, collision_down, collision_left}, sweep_done, mem_rden);
        end
        total++;
        if (exp_addr_q.size() !== 0) begin
            bad++; $display("FAIL reset_mid_reads: got %0d probes pending want 0", exp_addr_q.size());
        end
        exp_addr_q.delete();
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b1;
        push_sweep(80, 80, 8, 1'b1);
        @(negedge clock);
        enable = 1'b0;
        wait_done(30, c);
        total++;
        if (c < 0 || c + 1 !== 11 || collision_right !== 1'b1) begin
            bad++; $display("FAIL reset_mid_restart: got cyc=%0d right=%b want 11 and 1", c + 1, collision_right);
        end
    endtask

    task automatic test_enable_drop();
        int n, dn, act;
        @(negedge clock);
        player_x = 100;
        player_y = 100;
        enable = 1'b1;
        push_sweep(100, 100, 8, 1'b1);
        n = 0; dn = -1;
        while (dn < 0 && n < 40) begin
            @(negedge clock);
            n++;
            if (n == 4) enable = 1'b0;
            if (sweep_done) dn = n;
        end
        total++;
        if (dn !== 11) begin bad++; $display("FAIL drop_done: got cycle %0d want 11", dn); end
        act = 0;
        repeat (15) begin
            @(negedge clock);
            if (mem_rden || sweep_done) act++;
        end
        total++;
        if (act !== 0 || {collision_up, collision_right, collision_down, collision_left} !== 4'b0000) begin
            bad++; $display("FAIL drop_hold: got activity=%0d flags=%b want 0 and 0000", act,
                            {collision_up, collision_right, collision_down, collision_left});
        end
    endtask

    initial begin
        test_reset();
        test_open_maze();
        test_right_wall();
        test_edges();
        test_mid_change();
        test_reset_mid();
        test_enable_drop();
        total++;
        if (exp_addr_q.size() !== 0 || exp_flag_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d reads, %0d sweeps pending want 0,0",
                            exp_addr_q.size(), exp_flag_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
